nand_cmd_sequencer: RTL and testbench

Host-side command sequencer in front of `nand_master`. Turns single high-level requests (init, read ID, read page, get status) into the `cmd_in`/`activate`/`busy` command sequence that `nand_master` expects, and streams result bytes out over a valid/ready interface. It is the only block that drives `nand_master`'s command port, and it replaces hand-timed testbench stimulus in the system build.

---
 rtl/nand_cmd_sequencer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_nand_cmd_sequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nand_cmd_sequencer
// Purpose  : Expands high-level requests (init, read ID, read page, status)
//            into the command/activate/busy handshake of nand_master and
//            streams the returned bytes over a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module nand_cmd_sequencer #(
    parameter int         ID_BYTES   = 5,
    parameter int         PAGE_BYTES = 528,
    parameter logic [7:0] CE_SEL     = 8'h00,
    parameter int         BUSY_TO    = 4096
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    output logic       req_ready,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_last,
    input  logic       byte_ready,
    output logic       done,
    output logic       error,
    output logic       initialized,
    output logic [5:0] nm_cmd,
    output logic       nm_activate,
    output logic [7:0] nm_data_in,
    input  logic       nm_busy,
    input  logic [7:0] nm_data_out
);

    localparam int CNT_W = $clog2(PAGE_BYTES + 1);
    localparam int TO_W  = $clog2(BUSY_TO + 1);

    localparam logic [CNT_W-1:0] ID_CNT   = CNT_W'(ID_BYTES);
    localparam logic [CNT_W-1:0] PAGE_CNT = CNT_W'(PAGE_BYTES);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TO - 1);

    localparam logic [5:0] M_RESET               = 6'h01;
    localparam logic [5:0] M_NAND_RESET          = 6'h04;
    localparam logic [5:0] M_NAND_READ_ID        = 6'h06;
    localparam logic [5:0] M_NAND_READ           = 6'h09;
    localparam logic [5:0] MI_GET_STATUS         = 6'h0D;
    localparam logic [5:0] MI_CHIP_ENABLE        = 6'h0E;
    localparam logic [5:0] MI_RESET_INDEX        = 6'h12;
    localparam logic [5:0] MI_GET_ID_BYTE        = 6'h13;
    localparam logic [5:0] MI_GET_DATA_PAGE_BYTE = 6'h15;

    localparam logic [1:0] OP_INIT      = 2'b00;
    localparam logic [1:0] OP_READ_ID   = 2'b01;
    localparam logic [1:0] OP_READ_PAGE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_SETTLE = 3'd2,
        S_WAIT   = 3'd3,
        S_EMIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       op_q;
    logic             in_init;      // running the init prefix ahead of op_q
    logic [1:0]       step;         // position within the fixed command list
    logic [CNT_W-1:0] byte_cnt;
    logic [TO_W-1:0]  wait_cnt;
    logic [7:0]       data_q;
    logic [5:0]       cmd_q;
    logic [7:0]       din_q;
    logic             init_q;

    logic [5:0]       cur_cmd;
    logic [7:0]       cur_din;
    logic             byte_step;
    logic [CNT_W-1:0] byte_total;
    logic             last_byte;
    logic             init_end;

    logic             accept;
    logic             issue_fire;
    logic             capture;
    logic             step_adv;
    logic             init_exit;
    logic             init_set;
    logic             byte_adv;
    logic             timeout;

    // Decode the command for the current step; byte steps repeat in place
    always_comb begin
        cur_cmd    = M_RESET;
        cur_din    = 8'h00;
        byte_step  = 1'b0;
        byte_total = ONE_CNT;
        if (in_init) begin
            case (step)
                2'd0:    cur_cmd = M_RESET;
                2'd1: begin
                    cur_cmd = MI_CHIP_ENABLE;
                    cur_din = CE_SEL;
                end
                default: cur_cmd = M_NAND_RESET;
            endcase
        end else begin
            case (op_q)
                OP_READ_ID: begin
                    byte_total = ID_CNT;
                    if (step == 2'd0) begin
                        cur_cmd = M_NAND_READ_ID;
                    end else begin
                        cur_cmd   = MI_GET_ID_BYTE;
                        byte_step = 1'b1;
                    end
                end
                OP_READ_PAGE: begin
                    byte_total = PAGE_CNT;
                    case (step)
                        2'd0:    cur_cmd = MI_RESET_INDEX;
                        2'd1:    cur_cmd = M_NAND_READ;
                        2'd2:    cur_cmd = MI_RESET_INDEX;
                        default: begin
                            cur_cmd   = MI_GET_DATA_PAGE_BYTE;
                            byte_step = 1'b1;
                        end
                    endcase
                end
                OP_INIT: cur_cmd = M_NAND_RESET;  // op 00 completes inside the init prefix
                default: begin
                    cur_cmd   = MI_GET_STATUS;
                    byte_step = 1'b1;
                end
            endcase
        end
    end

    assign last_byte = (byte_cnt == byte_total - ONE_CNT);
    assign init_end  = in_init && (step == 2'd2);

    // Next-state and per-cycle control strobes
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue_fire = 1'b0;
        capture    = 1'b0;
        step_adv   = 1'b0;
        init_exit  = 1'b0;
        init_set   = 1'b0;
        byte_adv   = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!nm_busy) begin
                    issue_fire = 1'b1;
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: state_next = S_WAIT;
            S_WAIT: begin
                if (!nm_busy) begin
                    capture = 1'b1;
                    if (byte_step) begin
                        state_next = S_EMIT;
                    end else if (init_end) begin
                        init_set = 1'b1;
                        if (op_q == OP_INIT) begin
                            state_next = S_DONE;
                        end else begin
                            init_exit  = 1'b1;
                            state_next = S_ISSUE;
                        end
                    end else begin
                        step_adv   = 1'b1;
                        state_next = S_ISSUE;
                    end
                end else if (wait_cnt == TO_LAST) begin
                    timeout    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_EMIT: begin
                if (byte_ready) begin
                    if (last_byte) begin
                        state_next = S_DONE;
                    end else begin
                        byte_adv   = 1'b1;
                        state_next = S_ISSUE;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register and sequence bookkeeping
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state    <= S_IDLE;
            op_q     <= 2'b00;
            in_init  <= 1'b0;
            step     <= 2'd0;
            byte_cnt <= '0;
            wait_cnt <= '0;
            data_q   <= 8'h00;
            cmd_q    <= 6'h00;
            din_q    <= 8'h00;
            init_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q     <= req_op;
                in_init  <= (req_op == OP_INIT) || !init_q;
                step     <= 2'd0;
                byte_cnt <= '0;
            end
            if (issue_fire) begin
                cmd_q    <= cur_cmd;
                din_q    <= cur_din;
                wait_cnt <= '0;
            end else if (state == S_WAIT && nm_busy) begin
                wait_cnt <= wait_cnt + TO_W'(1);
            end
            if (capture) begin
                data_q <= nm_data_out;
            end
            if (step_adv) begin
                step <= step + 2'd1;
            end
            if (init_exit) begin
                in_init <= 1'b0;
                step    <= 2'd0;
            end
            if (init_set) begin
                init_q <= 1'b1;
            end
            if (timeout) begin
                init_q <= 1'b0;
            end
            if (byte_adv) begin
                byte_cnt <= byte_cnt + ONE_CNT;
            end
        end
    end

    assign req_ready   = (state == S_IDLE) && nreset;
    assign nm_activate = issue_fire;
    assign nm_cmd      = (state == S_ISSUE) ? cur_cmd : cmd_q;
    assign nm_data_in  = (state == S_ISSUE) ? cur_din : din_q;
    assign byte_valid  = (state == S_EMIT);
    assign byte_last   = (state == S_EMIT) && last_byte;
    assign byte_data   = data_q;
    assign done        = (state == S_DONE);
    assign error       = timeout;
    assign initialized = init_q;

endmodule
`default_nettype wire

// File: tb/tb_nand_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nand_cmd_sequencer
// Purpose  : Self-checking bench for nand_cmd_sequencer with a behavioural
//            nand_master stand-in and a list-based expected-sequence model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nand_cmd_sequencer;

    localparam int         ID_N   = 5;
    localparam int         PAGE_N = 4;
    localparam int         TO     = 16;
    localparam logic [7:0] CE     = 8'h00;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_op = 2'b00;
    logic       req_ready;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       byte_ready = 1'b0;
    logic       done;
    logic       error;
    logic       initialized;
    logic [5:0] nm_cmd;
    logic       nm_activate;
    logic [7:0] nm_data_in;
    logic       nm_busy = 1'b0;
    logic [7:0] nm_data_out = 8'h00;

    nand_cmd_sequencer #(
        .ID_BYTES   (ID_N),
        .PAGE_BYTES (PAGE_N),
        .CE_SEL     (CE),
        .BUSY_TO    (TO)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_ready   (req_ready),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_last   (byte_last),
        .byte_ready  (byte_ready),
        .done        (done),
        .error       (error),
        .initialized (initialized),
        .nm_cmd      (nm_cmd),
        .nm_activate (nm_activate),
        .nm_data_in  (nm_data_in),
        .nm_busy     (nm_busy),
        .nm_data_out (nm_data_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // nand_master stand-in state
    logic [7:0]  id_mem [ID_N];
    logic [7:0]  page_mem [PAGE_N];
    logic [7:0]  status_val = 8'h00;
    int          id_idx = 0;
    int          pg_idx = 0;
    int          busy_len = 0;
    bit          stuck = 1'b0;
    int          ready_mode = 0;
    int          act_busy = 0;
    logic [5:0]  mcmd;

    // Observations and expectations
    logic [13:0] obs_cmd [$];
    logic [8:0]  obs_byte [$];
    logic [13:0] exp_cmd [$];
    logic [8:0]  exp_byte [$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          done_cyc = 0;
    int          err_cyc = 0;
    int          act_cyc = 0;
    int          acc_cyc = 0;
    bit          model_init = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Command receiver: records each activation, then plays busy and data
    initial forever begin
        @(negedge clk);
        if (nm_activate) begin
            mcmd = nm_cmd;
            obs_cmd.push_back({nm_cmd, nm_data_in});
            act_cyc = cyc;
            if (nm_busy) act_busy++;
            @(posedge clk);
            #1;
            case (mcmd)
                6'h06: begin id_idx = 0; nm_data_out = 8'($urandom); end
                6'h12: begin pg_idx = 0; nm_data_out = 8'($urandom); end
                6'h13: begin nm_data_out = id_mem[id_idx % ID_N]; id_idx++; end
                6'h15: begin nm_data_out = page_mem[pg_idx % PAGE_N]; pg_idx++; end
                6'h0D: nm_data_out = status_val;
                default: nm_data_out = 8'($urandom);
            endcase
            if (stuck) begin
                nm_busy = 1'b1;
                while (stuck) @(posedge clk);
                #1 nm_busy = 1'b0;
            end else if (busy_len > 0) begin
                nm_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 nm_busy = 1'b0;
            end
        end
    end

    // Consumer back-pressure
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       byte_ready = 1'b1;
            1:       byte_ready = ~byte_ready;
            default: byte_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor
    initial forever begin
        @(negedge clk);
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (error) begin err_cnt++; err_cyc = cyc; end
        if (byte_valid && byte_ready) obs_byte.push_back({byte_last, byte_data});
        if (req_valid && req_ready) acc_cyc = cyc;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag, input logic exp_ready);
        check({tag, "_req_ready"},   req_ready, exp_ready);
        check({tag, "_byte_valid"},  byte_valid, 0);
        check({tag, "_byte_last"},   byte_last, 0);
        check({tag, "_done"},        done, 0);
        check({tag, "_error"},       error, 0);
        check({tag, "_activate"},    nm_activate, 0);
        check({tag, "_initialized"}, initialized, 0);
        check({tag, "_nm_cmd"},      nm_cmd, 0);
        check({tag, "_nm_data_in"},  nm_data_in, 0);
        check({tag, "_byte_data"},   byte_data, 0);
    endtask

    // Expected command and byte lists, straight from the request rules
    task automatic build_expect(input logic [1:0] op);
        exp_cmd.delete();
        exp_byte.delete();
        if (op == 2'b00 || !model_init) begin
            exp_cmd.push_back({6'h01, 8'h00});
            exp_cmd.push_back({6'h0E, CE});
            exp_cmd.push_back({6'h04, 8'h00});
        end
        case (op)
            2'b01: begin
                exp_cmd.push_back({6'h06, 8'h00});
                for (int i = 0; i < ID_N; i++) begin
                    exp_cmd.push_back({6'h13, 8'h00});
                    exp_byte.push_back({(i == ID_N - 1), id_mem[i]});
                end
            end
            2'b10: begin
                exp_cmd.push_back({6'h12, 8'h00});
                exp_cmd.push_back({6'h09, 8'h00});
                exp_cmd.push_back({6'h12, 8'h00});
                for (int i = 0; i < PAGE_N; i++) begin
                    exp_cmd.push_back({6'h15, 8'h00});
                    exp_byte.push_back({(i == PAGE_N - 1), page_mem[i]});
                end
            end
            2'b11: begin
                exp_cmd.push_back({6'h0D, 8'h00});
                exp_byte.push_back({1'b1, status_val});
            end
            default: ;
        endcase
    endtask

    task automatic compare_lists(input string tag);
        check({tag, "_ncmd"}, obs_cmd.size(), exp_cmd.size());
        for (int i = 0; i < exp_cmd.size() && i < obs_cmd.size(); i++) begin
            check($sformatf("%s_cmd%0d", tag, i), obs_cmd[i][13:8], exp_cmd[i][13:8]);
            if (exp_cmd[i][13:8] == 6'h0E || exp_cmd[i][13:8] == 6'h06)
                check($sformatf("%s_din%0d", tag, i), obs_cmd[i][7:0], exp_cmd[i][7:0]);
        end
        check({tag, "_nbyte"}, obs_byte.size(), exp_byte.size());
        for (int i = 0; i < exp_byte.size() && i < obs_byte.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), obs_byte[i], exp_byte[i]);
        check({tag, "_act_busy"}, act_busy, 0);
    endtask

    task automatic run_op(input logic [1:0] op, input int hold_extra, input string tag);
        int d0;
        int e0;
        bit ok;
        build_expect(op);
        obs_cmd.delete();
        obs_byte.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        req_op    = op;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        check({tag, "_accept"}, ok, 1);
        @(posedge clk);
        #1;
        repeat (hold_extra) begin @(posedge clk); #1; end
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done || error) begin ok = done; break; end
        end
        check({tag, "_done_seen"}, ok, 1);
        repeat (4) begin @(posedge clk); #1; end
        compare_lists(tag);
        check({tag, "_done_cnt"}, done_cnt - d0, 1);
        check({tag, "_err_cnt"}, err_cnt - e0, 0);
        check({tag, "_initialized"}, initialized, 1);
        check({tag, "_idle"}, req_ready, 1);
        model_init = 1'b1;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;
        model_init = 1'b0;
    endtask

    initial begin
        bit ok;
        int e0;
        int d0;
        logic [1:0] rop;

        id_mem[0] = 8'hEC; id_mem[1] = 8'h76; id_mem[2] = 8'h5A;
        id_mem[3] = 8'h3F; id_mem[4] = 8'h74;
        for (int i = 0; i < PAGE_N; i++) page_mem[i] = 8'($urandom);

        // Reset values, during and after reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("in_rst", 1'b0);
        @(posedge clk);
        #1 nreset = 1'b1;
        @(negedge clk);
        check_reset("post_rst", 1'b1);
        @(posedge clk);
        #1;

        // Init with a slow device
        busy_len = 10;
        ready_mode = 0;
        run_op(2'b00, 0, "init");

        // Read ID from an uninitialized state pulls in init first
        do_reset();
        busy_len = 2;
        ready_mode = 2;
        run_op(2'b01, 0, "rdid");

        // Page read with alternating back-pressure and a stray request held high
        busy_len = 0;
        ready_mode = 1;
        run_op(2'b10, 3, "page");

        // Status: single byte, five cycles from acceptance to done
        ready_mode = 0;
        status_val = 8'hE0;
        run_op(2'b11, 0, "status");
        check("status_latency", done_cyc - acc_cyc, 5);
        check("status_cmd_hold", nm_cmd, 6'h0D);

        // Randomized requests
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < ID_N; i++) id_mem[i] = 8'($urandom);
            for (int i = 0; i < PAGE_N; i++) page_mem[i] = 8'($urandom);
            status_val = 8'($urandom);
            busy_len   = $urandom_range(0, 3);
            ready_mode = $urandom_range(0, 2);
            rop        = 2'($urandom_range(0, 3));
            run_op(rop, 0, $sformatf("rnd%0d", k));
        end

        // Busy stuck high after the first command: timeout
        busy_len = 0;
        ready_mode = 0;
        obs_cmd.delete();
        obs_byte.delete();
        e0 = err_cnt;
        d0 = done_cnt;
        stuck = 1'b1;
        req_op = 2'b11;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        check("to_accept", ok, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (error) begin ok = 1'b1; break; end
        end
        check("to_error_seen", ok, 1);
        @(negedge clk);
        check("to_req_ready", req_ready, 1);
        check("to_initialized", initialized, 0);
        check("to_error_width", error, 0);
        check("to_latency", err_cyc - act_cyc, TO + 1);
        stuck = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        check("to_err_cnt", err_cnt - e0, 1);
        check("to_no_done", done_cnt - d0, 0);
        check("to_ncmd", obs_cmd.size(), 1);
        if (obs_cmd.size() > 0) check("to_cmd", obs_cmd[0][13:8], model_init ? 6'h0D : 6'h01);
        model_init = 1'b0;

        // Status after timeout re-runs init
        status_val = 8'($urandom);
        run_op(2'b11, 0, "after_to");

        // Reset in the middle of a page stream
        ready_mode = 1;
        busy_len = 0;
        for (int i = 0; i < PAGE_N; i++) page_mem[i] = 8'($urandom);
        obs_cmd.delete();
        obs_byte.delete();
        req_op = 2'b10;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        check("mid_accept", ok, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (obs_byte.size() >= 2) begin ok = 1'b1; break; end
        end
        check("mid_stream", ok, 1);
        #1 nreset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset("mid_rst", 1'b0);
        @(posedge clk);
        #1 nreset = 1'b1;
        model_init = 1'b0;
        ready_mode = 0;
        status_val = 8'($urandom);
        run_op(2'b11, 0, "post_mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
